stepper_multi_dispenser: RTL and testbench

Parametrised N-channel stepper sequencer for the colour dispensers.
- On `start`, it latches a per-channel step count and a direction.
- It then drives each channel's 4-wire coil outputs in turn (channel 0 first, N_CH-1 last), one step per step tick.
- A fixed settle gap separates channels. `done` pulses when all channels finish.
- Sits between the colour-recipe logic and the motor driver pins. Replaces per-colour hardwired timing with run-time step counts.

---
 rtl/stepper_multi_dispenser.sv | 176 +++++++++++++++++
 tb/tb_stepper_multi_dispenser.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_multi_dispenser.sv
// N-channel stepper sequencer: steps each channel in turn by a latched count, with a settle gap between channels.
// Define HALF_STEP_EN for 8-phase half-stepping (steps_flat then counts half-steps); default is 4-phase full-step.
module stepper_multi_dispenser #(
    parameter int N_CH         = 3,
    parameter int CNT_W        = 10,
    parameter int TICK_PERIOD  = 524288,
    parameter int SETTLE_TICKS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    dir,
    input  logic [N_CH*CNT_W-1:0]   steps_flat,
    output logic [4*N_CH-1:0]       coils,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(N_CH)-1:0] active_ch
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int TCK_W = $clog2(TICK_PERIOD);
    localparam int ST_W  = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
`ifdef HALF_STEP_EN
    localparam int PH_W = 3;
`else
    localparam int PH_W = 2;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, RUN, SETTLE, DONE} state_t;

    function automatic logic [3:0] phase_coils(input logic [PH_W-1:0] ph);
        logic [3:0] c;
        c = 4'b0000;
`ifdef HALF_STEP_EN
        case (ph)
            3'd0: c = 4'b0001;
            3'd1: c = 4'b0011;
            3'd2: c = 4'b0010;
            3'd3: c = 4'b0110;
            3'd4: c = 4'b0100;
            3'd5: c = 4'b1100;
            3'd6: c = 4'b1000;
            3'd7: c = 4'b1001;
            default: c = 4'b0000;
        endcase
`else
        case (ph)
            2'd0: c = 4'b0001;
            2'd1: c = 4'b0010;
            2'd2: c = 4'b0100;
            2'd3: c = 4'b1000;
            default: c = 4'b0000;
        endcase
`endif
        return c;
    endfunction

    state_t                      state_reg, state_next;
    logic [TCK_W-1:0]            tick_cnt_reg;
    logic [CH_W-1:0]             ch_reg, ch_next, coil_ch_reg;
    logic                        dir_reg;
    logic [CNT_W-1:0]            remaining_reg;
    logic [ST_W-1:0]             settle_reg;
    logic [3:0]                  coil_reg, coil_next;
    logic [N_CH-1:0][CNT_W-1:0]  count_all;
    logic [N_CH-1:0][PH_W-1:0]   phase_all;
    logic                        tick, accept, last_ch, step_now, settle_end;

    assign tick       = (tick_cnt_reg == TCK_W'(TICK_PERIOD - 1));
    assign accept     = (state_reg == IDLE) && start && !abort;
    assign last_ch    = (ch_reg == CH_W'(N_CH - 1));
    assign step_now   = (state_reg == RUN) && tick && !abort;
    assign settle_end = tick && (settle_reg == ST_W'(SETTLE_TICKS - 1));

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign active_ch = ch_reg;

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        coil_next  = 4'b0000;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = LOAD;
                    ch_next    = '0;
                end
            end
            LOAD: begin
                if (count_all[ch_reg] == '0) begin
                    if (last_ch) state_next = DONE;
                    else         ch_next    = ch_reg + CH_W'(1);
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                coil_next = tick ? phase_coils(phase_all[ch_reg]) : coil_reg;
                if (tick && remaining_reg == CNT_W'(1)) begin
                    if (last_ch) begin
                        state_next = DONE;
                    end else if (SETTLE_TICKS == 0) begin
                        state_next = LOAD;
                        ch_next    = ch_reg + CH_W'(1);
                    end else begin
                        state_next = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (settle_end) begin
                    state_next = LOAD;
                    ch_next    = ch_reg + CH_W'(1);
                end else begin
                    coil_next = coil_reg;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort && state_reg != IDLE) begin
            state_next = IDLE;
            coil_next  = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            tick_cnt_reg  <= '0;
            ch_reg        <= '0;
            coil_ch_reg   <= '0;
            dir_reg       <= 1'b0;
            remaining_reg <= '0;
            settle_reg    <= '0;
            coil_reg      <= 4'b0000;
        end else begin
            state_reg   <= state_next;
            ch_reg      <= ch_next;
            coil_reg    <= coil_next;
            // The coil register lags the FSM by a cycle, so remember which channel it belongs to.
            coil_ch_reg <= ch_reg;
            if (accept || tick) tick_cnt_reg <= '0;
            else                tick_cnt_reg <= tick_cnt_reg + TCK_W'(1);
            if (accept) dir_reg <= dir;
            if (state_reg == LOAD)  remaining_reg <= count_all[ch_reg];
            else if (step_now)      remaining_reg <= remaining_reg - CNT_W'(1);
            if (state_reg != SETTLE) settle_reg <= '0;
            else if (tick)           settle_reg <= settle_reg + ST_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] count_reg;
            logic [PH_W-1:0]  phase_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    count_reg <= '0;
                    phase_reg <= '0;
                end else begin
                    if (accept) count_reg <= steps_flat[gi*CNT_W +: CNT_W];
                    // Phase pointer names the pattern applied at the next step, then moves one position in dir.
                    if (step_now && ch_reg == CH_W'(gi))
                        phase_reg <= dir_reg ? phase_reg - PH_W'(1) : phase_reg + PH_W'(1);
                end
            end

            assign count_all[gi]     = count_reg;
            assign phase_all[gi]     = phase_reg;
            assign coils[4*gi +: 4]  = (coil_ch_reg == CH_W'(gi)) ? coil_reg : 4'b0000;
        end
    endgenerate
endmodule

// File: tb/tb_stepper_multi_dispenser.sv
// Scoreboard bench: each run pushes its expected coil steps; a negedge monitor pops one per coil change.
module tb_stepper_multi_dispenser;
    localparam int N_CH = 3;
    localparam int CNT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst, start, abort, dir;
    logic [N_CH*CNT_W-1:0] steps_flat;
    logic [4*N_CH-1:0]     coils;
    logic                  busy, done;
    logic [1:0]            active_ch;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int model_ph[N_CH];
    logic [11:0] exp_q[$];
    logic [11:0] prev_coils = '0;
    logic [11:0] mon_exp;

    stepper_multi_dispenser #(
        .N_CH(N_CH), .CNT_W(CNT_W), .TICK_PERIOD(4), .SETTLE_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dir(dir),
        .steps_flat(steps_flat), .coils(coils), .busy(busy), .done(done),
        .active_ch(active_ch)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] full_step(input int ph);
        case (ph)
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic void push_steps(input int ch, input int n, input logic d);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(12'(full_step(model_ph[ch])) << (4 * ch));
            model_ph[ch] = d ? (model_ph[ch] + 3) % 4 : (model_ph[ch] + 1) % 4;
        end
    endfunction

    always @(negedge clk) begin
        if (done) done_seen++;
        if (coils !== prev_coils && coils !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL coil_step: got %h, expected no step", coils);
            end else begin
                mon_exp = exp_q.pop_front();
                if (coils !== mon_exp) begin
                    errors++;
                    $display("FAIL coil_step: got %h, expected %h", coils, mon_exp);
                end else begin
                    $display("step coils=%h ch=%0d", coils, active_ch);
                end
            end
        end
        prev_coils = coils;
    end

    task automatic pulse_start(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2, input logic d);
        @(negedge clk); #1;
        steps_flat = {c2, c1, c0};
        dir = d;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    // Returns the cycle index at which done was seen (counted from return of pulse_start), -1 on timeout.
    task automatic wait_done(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk); #1;
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b0; steps_flat = '0;
        repeat (3) @(negedge clk);
        #1;
        checks += 4;
        if (coils !== 12'h000) begin errors++; $display("FAIL reset_coils: got %h expected 000", coils); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (active_ch !== 2'd0) begin errors++; $display("FAIL reset_active_ch: got %0d expected 0", active_ch); end
        rst = 1'b0;
        for (int c = 0; c < N_CH; c++) model_ph[c] = 0;
        $display("reset checked");
    endtask

    task automatic test_sequence;
        int first, n0010, done_at, d0;
        logic busy_drop;
        first = -1; n0010 = 0; done_at = -1; busy_drop = 1'b0;
        push_steps(0, 2, 1'b0); push_steps(1, 3, 1'b0); push_steps(2, 1, 1'b0);
        d0 = done_seen;
        pulse_start(4'd2, 4'd3, 4'd1, 1'b0);
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk); #1;
            if (first < 0 && coils !== '0) first = i;
            if (coils === 12'h002) n0010++;
            if (busy !== 1'b1) busy_drop = 1'b1;
            if (done) begin done_at = i; break; end
        end
        @(negedge clk); #1;
        checks += 7;
        if (first != 4) begin errors++; $display("FAIL seq_first_step: got %0d expected 4", first); end
        if (n0010 != 8) begin errors++; $display("FAIL seq_settle_len: got %0d expected 8", n0010); end
        if (busy_drop) begin errors++; $display("FAIL seq_busy_high: got drop expected held"); end
        if (done_at != 40) begin errors++; $display("FAIL seq_done_time: got %0d expected 40", done_at); end
        if (done_seen - d0 != 1) begin errors++; $display("FAIL seq_done_count: got %0d expected 1", done_seen - d0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL seq_drain: got %0d left expected 0", exp_q.size()); end
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL seq_after_done: got busy=%b done=%b expected 0 0", busy, done); end
        $display("sequence run done_at=%0d", done_at);
    endtask

    task automatic test_reverse_skip;
        int step_at, done_at, d0;
        step_at = -1; done_at = -1;
        push_steps(0, 1, 1'b1);
        d0 = done_seen;
        pulse_start(4'd1, 4'd0, 4'd0, 1'b1);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk); #1;
            if (step_at < 0 && coils !== '0) step_at = i;
            if (done) begin done_at = i; break; end
        end
        checks += 3;
        if (step_at != 4 || done_at - step_at != 10) begin
            errors++; $display("FAIL rev_timing: got step=%0d done=%0d expected 4 14", step_at, done_at);
        end
        if (done_seen - d0 != 1) begin errors++; $display("FAIL rev_done_count: got %0d expected 1", done_seen - d0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL rev_drain: got %0d left expected 0", exp_q.size()); end
        $display("reverse/skip run done_at=%0d", done_at);
    endtask

    task automatic test_all_zero;
        int done_at, d0;
        logic lit;
        lit = 1'b0;
        d0 = done_seen;
        pulse_start(4'd0, 4'd0, 4'd0, 1'b0);
        done_at = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk); #1;
            if (coils !== '0) lit = 1'b1;
            if (done) begin done_at = i; break; end
        end
        checks += 3;
        if (done_at != 3) begin errors++; $display("FAIL zero_done_time: got %0d expected 3", done_at); end
        if (lit) begin errors++; $display("FAIL zero_coils: got energised expected 000"); end
        if (done_seen - d0 != 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", done_seen - d0); end
        $display("all-zero run done_at=%0d", done_at);
    endtask

    task automatic test_abort;
        int d0, done_at;
        logic drained;
        drained = 1'b0;
        push_steps(0, 1, 1'b0); push_steps(1, 2, 1'b0);
        d0 = done_seen;
        pulse_start(4'd1, 4'd5, 4'd0, 1'b0);
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) begin drained = 1'b1; break; end
        end
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        checks += 3;
        if (!drained) begin errors++; $display("FAIL abort_reach_ch1: got timeout expected two ch1 steps"); end
        if (coils !== 12'h000) begin errors++; $display("FAIL abort_coils: got %h expected 000", coils); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (done_seen != d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_seen - d0); end
        push_steps(1, 2, 1'b0);
        pulse_start(4'd0, 4'd2, 4'd0, 1'b0);
        wait_done(100, done_at);
        checks += 2;
        if (done_at < 0) begin errors++; $display("FAIL abort_rerun_done: got timeout expected done"); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL abort_rerun_drain: got %0d left expected 0", exp_q.size()); end
        $display("abort then rerun done_at=%0d", done_at);
    endtask

    task automatic test_start_ignored;
        int d0, done_at;
        logic went_busy;
        went_busy = 1'b0;
        d0 = done_seen;
        @(negedge clk); #1;
        steps_flat = {4'd1, 4'd1, 4'd1}; dir = 1'b0; start = 1'b1; abort = 1'b1;
        @(negedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (busy) went_busy = 1'b1;
        end
        checks += 2;
        if (went_busy) begin errors++; $display("FAIL abort_start_busy: got 1 expected 0"); end
        if (done_seen != d0) begin errors++; $display("FAIL abort_start_done: got %0d expected 0", done_seen - d0); end

        push_steps(0, 1, 1'b0); push_steps(1, 1, 1'b0); push_steps(2, 1, 1'b0);
        d0 = done_seen;
        pulse_start(4'd1, 4'd1, 4'd1, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        steps_flat = {4'd5, 4'd5, 4'd5}; dir = 1'b1; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(200, done_at);
        checks += 3;
        if (done_at != 22) begin errors++; $display("FAIL busy_start_time: got %0d expected 22", done_at); end
        if (done_seen - d0 != 1) begin errors++; $display("FAIL busy_start_done: got %0d expected 1", done_seen - d0); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL busy_start_drain: got %0d left expected 0", exp_q.size()); end
        $display("start-ignore checks done_at=%0d", done_at);
    endtask

    task automatic test_all_ones;
        int done_at;
        push_steps(2, 15, 1'b0);
        pulse_start(4'd0, 4'd0, 4'd15, 1'b0);
        wait_done(300, done_at);
        checks += 2;
        if (done_at != 60) begin errors++; $display("FAIL ones_done_time: got %0d expected 60", done_at); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL ones_drain: got %0d left expected 0", exp_q.size()); end
        $display("all-ones count done_at=%0d", done_at);
    endtask

    task automatic test_reset_mid_settle;
        int done_at;
        logic drained;
        drained = 1'b0;
        push_steps(0, 2, 1'b0);
        pulse_start(4'd2, 4'd1, 4'd1, 1'b0);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) begin drained = 1'b1; break; end
        end
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        checks += 5;
        if (!drained) begin errors++; $display("FAIL rst_reach_settle: got timeout expected ch0 steps"); end
        if (coils !== 12'h000) begin errors++; $display("FAIL rst_coils: got %h expected 000", coils); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        if (active_ch !== 2'd0) begin errors++; $display("FAIL rst_active_ch: got %0d expected 0", active_ch); end
        for (int c = 0; c < N_CH; c++) model_ph[c] = 0;
        exp_q.delete();
        push_steps(0, 1, 1'b0); push_steps(1, 1, 1'b0);
        pulse_start(4'd1, 4'd1, 4'd0, 1'b0);
        wait_done(200, done_at);
        checks += 2;
        if (done_at < 0) begin errors++; $display("FAIL rst_rerun_done: got timeout expected done"); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL rst_rerun_drain: got %0d left expected 0", exp_q.size()); end
        $display("reset mid-settle then rerun done_at=%0d", done_at);
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_reverse_skip();
        test_all_zero();
        test_abort();
        test_start_ignored();
        test_all_ones();
        test_reset_mid_settle();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
